// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DROP
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // IF/ID register view at the default 32-bit PC width.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry capture/release buffer for a response that arrives while decode is stalled.
module if_hold_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic            full,
    output logic [XLEN-1:0] pc_out,
    output logic [31:0]     instr_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full      <= 1'b0;
            pc_out    <= '0;
            instr_out <= '0;
        end else if (load) begin
            full      <= 1'b1;
            pc_out    <= pc_in;
            instr_out <= instr_in;
        end else if (clear) begin
            full      <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch stage: PC register, single-outstanding imem handshake and IF/ID register.
// Optional IFETCH_PERF_CNT_EN adds fetched/dropped instruction counters.
module if_fetch_ctrl
    import if_fetch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_pc,
    input  logic            stall_if_id,
    input  logic            flush_if_id,
    input  logic            branch_taken_ex,
    input  logic [XLEN-1:0] branch_target_ex,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
`endif
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_inc, target;
    logic            accept, load_new, buf_load, buf_clear, buf_full, drop;
    logic [XLEN-1:0] new_pc, buf_pc;
    logic [31:0]     new_instr, buf_instr;

    assign target    = {branch_target_ex[XLEN-1:2], 2'b00};
    assign pc_inc    = pc_q + XLEN'(4);
    assign imem_req  = (state_q == S_FETCH) && !stall_pc && !branch_taken_ex && !reset;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    if_hold_buf #(.XLEN(XLEN)) u_hold_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (buf_clear),
        .pc_in     (pc_q),
        .instr_in  (imem_rdata),
        .full      (buf_full),
        .pc_out    (buf_pc),
        .instr_out (buf_instr)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        load_new  = 1'b0;
        new_pc    = pc_q;
        new_instr = imem_rdata;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        drop      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (branch_taken_ex) begin
                    pc_d = target;
                end else if (accept) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken_ex) begin
                    pc_d = target;
                    if (imem_rvalid) begin
                        drop    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_rvalid) begin
                    if (stall_if_id) begin
                        buf_load = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        load_new = 1'b1;
                        pc_d     = pc_inc;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken_ex) begin
                    buf_clear = 1'b1;
                    drop      = 1'b1;
                    pc_d      = target;
                    state_d   = S_FETCH;
                end else if (!stall_if_id && buf_full) begin
                    load_new  = 1'b1;
                    new_pc    = buf_pc;
                    new_instr = buf_instr;
                    buf_clear = 1'b1;
                    pc_d      = pc_inc;
                    state_d   = S_FETCH;
                end
            end
            S_DROP: begin
                if (branch_taken_ex) begin
                    pc_d = target;
                end
                if (imem_rvalid) begin
                    drop    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // A redirect or flush wins over the load; the fetched word is then lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
        end else if (branch_taken_ex || flush_if_id) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end else if (stall_if_id) begin
            if_id_valid <= if_id_valid;
        end else if (load_new) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= new_pc;
            if_id_instr <= new_instr;
        end else begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (load_new && !flush_if_id) perf_fetched <= perf_fetched + 32'd1;
            if (drop)                     perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed table-driven bench for if_fetch_ctrl plus reset/wrap sequences.
module tb_if_fetch_ctrl;
    import if_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_pc, stall_if_id, flush_if_id, branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_pc, if_id_instr;
    logic        imem_req1, if_id_valid1;
    logic [31:0] imem_addr1, if_id_pc1, if_id_instr1;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_dropped, perf_fetched1, perf_dropped1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_pc         (stall_pc),
        .stall_if_id      (stall_if_id),
        .flush_if_id      (flush_if_id),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetched     (perf_fetched),
        .perf_dropped     (perf_dropped),
`endif
        .if_id_valid      (if_id_valid),
        .if_id_pc         (if_id_pc),
        .if_id_instr      (if_id_instr)
    );

    if_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk              (clk),
        .reset            (reset),
        .stall_pc         (stall_pc),
        .stall_if_id      (stall_if_id),
        .flush_if_id      (flush_if_id),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .imem_req         (imem_req1),
        .imem_addr        (imem_addr1),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetched     (perf_fetched1),
        .perf_dropped     (perf_dropped1),
`endif
        .if_id_valid      (if_id_valid1),
        .if_id_pc         (if_id_pc1),
        .if_id_instr      (if_id_instr1)
    );

    typedef struct {
        logic        sp, sid, fl, br;
        logic [31:0] tgt;
        logic        rdy, rv;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        if_id_t      ifid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic av(input logic sp, input logic sid, input logic fl, input logic br,
                      input logic [31:0] tgt, input logic rdy, input logic rv,
                      input logic [31:0] rdata, input logic req, input logic [31:0] addr,
                      input logic v, input logic [31:0] vpc, input logic [31:0] vin);
        vec_t t;
        t.sp = sp; t.sid = sid; t.fl = fl; t.br = br; t.tgt = tgt;
        t.rdy = rdy; t.rv = rv; t.rdata = rdata; t.req = req; t.addr = addr;
        t.ifid = '{valid: v, pc: vpc, instr: vin};
        vecs.push_back(t);
    endtask

    task automatic idle_inputs();
        stall_pc = 0; stall_if_id = 0; flush_if_id = 0; branch_taken_ex = 0;
        branch_target_ex = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    endtask

    initial begin
        //  sp sid fl br tgt           rdy rv rdata          req addr        v  pc       instr
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h000, 0, 32'h000, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 1, 32'h00500093, 0, 32'h000, 0, 32'h000, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h004, 1, 32'h000, 32'h00500093);
        av(0, 0, 0, 0, 32'h0,        0, 1, 32'h00100113, 0, 32'h004, 0, 32'h000, 32'h13);
        av(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h008, 1, 32'h004, 32'h00100113);
        av(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h008, 0, 32'h004, 32'h13);
        av(1, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h008, 0, 32'h004, 32'h13);
        av(1, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h008, 0, 32'h004, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h008, 0, 32'h004, 32'h13);
        av(0, 1, 0, 0, 32'h0,        0, 1, 32'h00208193, 0, 32'h008, 0, 32'h004, 32'h13);
        av(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h008, 0, 32'h004, 32'h13);
        av(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h008, 0, 32'h004, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h008, 0, 32'h004, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h00C, 1, 32'h008, 32'h00208193);
        av(0, 0, 0, 1, 32'h103,      0, 0, 32'h0,        0, 32'h00C, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 32'h100, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100, 0, 32'h008, 32'h13);
        av(0, 0, 0, 1, 32'h200,      1, 0, 32'h0,        0, 32'h100, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200, 0, 32'h008, 32'h13);
        av(0, 0, 0, 1, 32'h305,      0, 1, 32'h11111111, 0, 32'h200, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h304, 0, 32'h008, 32'h13);
        av(0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h304, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 1, 32'h00300213, 0, 32'h304, 0, 32'h008, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h308, 1, 32'h304, 32'h00300213);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h308, 0, 32'h304, 32'h13);
        av(0, 1, 0, 0, 32'h0,        0, 1, 32'h0000AAAA, 0, 32'h308, 0, 32'h304, 32'h13);
        av(0, 1, 0, 1, 32'h400,      0, 0, 32'h0,        0, 32'h308, 0, 32'h304, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h400, 0, 32'h304, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h400, 0, 32'h304, 32'h13);
        av(0, 0, 0, 1, 32'h500,      0, 0, 32'h0,        0, 32'h400, 0, 32'h304, 32'h13);
        av(0, 0, 0, 1, 32'h600,      0, 0, 32'h0,        0, 32'h500, 0, 32'h304, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h600, 0, 32'h304, 32'h13);
        av(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h600, 0, 32'h304, 32'h13);
        av(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h600, 0, 32'h304, 32'h13);

        idle_inputs();
        reset = 1;
        repeat (3) @(negedge clk);
        #1;
        check("req_in_reset", 32'(imem_req), 32'h0);
        @(negedge clk);
        reset = 0;
        #1;
        check("rst_valid", 32'(if_id_valid), 32'h0);
        check("rst_pc", if_id_pc, 32'h0);
        check("rst_instr", if_id_instr, 32'h13);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_addr_wrap", imem_addr1, 32'hFFFF_FFFC);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            stall_pc = vecs[i].sp;   stall_if_id = vecs[i].sid;
            flush_if_id = vecs[i].fl; branch_taken_ex = vecs[i].br;
            branch_target_ex = vecs[i].tgt; imem_ready = vecs[i].rdy;
            imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
            #1;
            check($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].ifid.valid));
            check($sformatf("v%0d_pc", i), if_id_pc, vecs[i].ifid.pc);
            check($sformatf("v%0d_instr", i), if_id_instr, vecs[i].ifid.instr);
            if (i == 0) check("wrap_addr_first", imem_addr1, 32'hFFFF_FFFC);
            if (i == 2) check("wrap_addr_next", imem_addr1, 32'h0000_0000);
        end
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd4);
        check("perf_dropped", perf_dropped, 32'd4);
`endif

        // Reset while a request is outstanding, then a late response.
        @(negedge clk);
        idle_inputs();
        reset = 1;
        #1;
        check("req_reset_wait", 32'(imem_req), 32'h0);
        @(negedge clk);
        reset = 0;
        imem_rvalid = 1;
        imem_rdata = 32'h0BAD_0BAD;
        #1;
        check("post_rst_addr", imem_addr, 32'h0);
        check("post_rst_req", 32'(imem_req), 32'h1);
        check("post_rst_valid", 32'(if_id_valid), 32'h0);
        check("post_rst_addr_wrap", imem_addr1, 32'hFFFF_FFFC);
        check("post_rst_req_wrap", 32'(imem_req1), 32'h1);
`ifdef IFETCH_PERF_CNT_EN
        check("post_rst_perf", perf_fetched, 32'd0);
`endif
        @(negedge clk);
        imem_rvalid = 0;
        #1;
        check("late_rv_valid", 32'(if_id_valid), 32'h0);
        check("late_rv_instr", if_id_instr, 32'h13);
        check("late_rv_pc", if_id_pc, 32'h0);
        check("late_rv_addr", imem_addr, 32'h0);
        check("late_rv_valid_wrap", 32'(if_id_valid1), 32'h0);
        check("late_rv_pc_wrap", if_id_pc1, 32'h0);
        check("late_rv_instr_wrap", if_id_instr1, 32'h13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
